// File: rtl/date_edit_ctrl_pkg.sv
// rtl/date_edit_ctrl_pkg.sv - shared types for the date edit controller
// Purpose: the FSM state encoding, the field_sel codes, and a state-to-field decode.
// Ports: none (package).
package date_ctrl_pkg;

  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    EDIT_DAY   = 2'd1,
    EDIT_MONTH = 2'd2,
    EDIT_YEAR  = 2'd3
  } state_e;

  localparam logic [1:0] FLD_NONE = 2'b00;
  localparam logic [1:0] FLD_DAY  = 2'b01;
  localparam logic [1:0] FLD_MON  = 2'b10;
  localparam logic [1:0] FLD_YEAR = 2'b11;

  function automatic logic [1:0] field_of(input state_e s);
    case (s)
      EDIT_DAY:   field_of = FLD_DAY;
      EDIT_MONTH: field_of = FLD_MON;
      EDIT_YEAR:  field_of = FLD_YEAR;
      default:    field_of = FLD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/date_edit_ctrl_key_autorepeat.sv
// rtl/date_edit_ctrl_key_autorepeat.sv - key edge detect with hold-to-auto-repeat
// Purpose: emits a step on the rising edge of key, then after DELAY held ticks one
//          step, then one step every RATE held ticks. step is combinational; the
//          parent registers it.
// Ports:  clk, rst (async, active high), tick (1 ms enable), key (debounced level),
//         clr (clears the hold counter and suppresses step), step (out).
module key_autorepeat #(
  parameter int DELAY = 500,
  parameter int RATE  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key,
  input  logic clr,
  output logic step
);

  localparam int MAXC = (DELAY > RATE) ? DELAY : RATE;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DELAY_C = CW'(DELAY);
  localparam logic [CW-1:0] RATE_C  = CW'(RATE);

  logic          key_q;
  logic          rep_q, rep_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] target;
  logic          fire;

  // rep_q marks that the initial delay has elapsed; the counter then restarts
  // from zero and measures the shorter repeat interval. It never passes its
  // target, so it cannot wrap.
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    target  = rep_q ? RATE_C : DELAY_C;
    fire    = 1'b0;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    if (clr || !key) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (tick) begin
      if (cnt_inc == target) begin
        fire  = 1'b1;
        cnt_d = '0;
        rep_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  assign step = key & ~clr & (~key_q | fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= 1'b0;
      rep_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      key_q <= key;
      rep_q <= rep_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/date_edit_ctrl.sv
// rtl/date_edit_ctrl.sv - manual date edit sequencer for the day/month/year chain
// Purpose: MODE walks NORMAL -> EDIT_DAY -> EDIT_MONTH -> EDIT_YEAR -> NORMAL; UP/DOWN
//          send 1-clk inc/dec pulses (with auto-repeat) to the selected counter;
//          end_of_day is held back while editing and replayed once on exit.
// Ports:  clk, rst (async, active high), tick_1ms (1 kHz enable),
//         btn_mode/btn_up/btn_down (debounced levels), eod_in (1-clk pulse),
//         eod_out, inc_d/dec_d, inc_m/dec_m, inc_y/dec_y (1-clk pulses),
//         edit_active, field_sel[1:0], blink (registered status).
module date_edit_ctrl
  import date_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int TIMEOUT_MS      = 10000,
  parameter int BLINK_HALF_MS   = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1ms,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       eod_in,
  output logic       eod_out,
  output logic       inc_d,
  output logic       dec_d,
  output logic       inc_m,
  output logic       dec_m,
  output logic       inc_y,
  output logic       dec_y,
  output logic       edit_active,
  output logic [1:0] field_sel,
  output logic       blink
);

  localparam int TW = $clog2(TIMEOUT_MS + 1);
  localparam int BW = $clog2(BLINK_HALF_MS + 1);
  localparam logic [TW-1:0] TO_C = TW'(TIMEOUT_MS);
  localparam logic [BW-1:0] BH_C = BW'(BLINK_HALF_MS);

  state_e        state_q, state_d;
  logic          mode_q, up_q, down_q;
  logic          mode_rise, key_edge, in_edit, timeout, entering;
  logic          key_clr, up_step, down_step, step_up, step_dn;
  logic [TW-1:0] idle_q, idle_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic          pend_q, pend_d;
  logic          eod_q, eod_d;
  logic [5:0]    pulse_q, pulse_d;  // {inc_d, dec_d, inc_m, dec_m, inc_y, dec_y}
  logic [1:0]    field_q, field_d;
  logic          edit_q, edit_d;

  assign mode_rise = btn_mode & ~mode_q;
  assign key_edge  = mode_rise | (btn_up & ~up_q) | (btn_down & ~down_q);
  assign in_edit   = (state_q != NORMAL);
  assign timeout   = in_edit & (idle_q == TO_C);

  // Hold counters stay idle outside edit, and a mode edge or a two-key chord
  // drops any step and restarts the hold delay.
  assign key_clr = mode_rise | (btn_up & btn_down) | ~in_edit;

  key_autorepeat #(.DELAY(REPEAT_DELAY_MS), .RATE(REPEAT_RATE_MS)) u_rep_up (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_1ms),
    .key  (btn_up),
    .clr  (key_clr),
    .step (up_step)
  );

  key_autorepeat #(.DELAY(REPEAT_DELAY_MS), .RATE(REPEAT_RATE_MS)) u_rep_down (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_1ms),
    .key  (btn_down),
    .clr  (key_clr),
    .step (down_step)
  );

  // A step that coincides with a timeout would land on a field being left.
  assign step_up = up_step & ~timeout;
  assign step_dn = down_step & ~timeout;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (mode_rise) begin
      case (state_q)
        NORMAL:     state_d = EDIT_DAY;
        EDIT_DAY:   state_d = EDIT_MONTH;
        EDIT_MONTH: state_d = EDIT_YEAR;
        default:    state_d = NORMAL;
      endcase
    end else if (timeout) begin
      state_d = NORMAL;
    end
  end

  // FSM: outputs (registered below)
  always_comb begin
    pulse_d = '0;
    if (step_up) begin
      case (state_q)
        EDIT_DAY:   pulse_d[5] = 1'b1;
        EDIT_MONTH: pulse_d[3] = 1'b1;
        EDIT_YEAR:  pulse_d[1] = 1'b1;
        default:    pulse_d    = '0;
      endcase
    end else if (step_dn) begin
      case (state_q)
        EDIT_DAY:   pulse_d[4] = 1'b1;
        EDIT_MONTH: pulse_d[2] = 1'b1;
        EDIT_YEAR:  pulse_d[0] = 1'b1;
        default:    pulse_d    = '0;
      endcase
    end
    field_d = field_of(state_d);
    edit_d  = (state_d != NORMAL);
  end

  // Idle timeout counter, saturating at TIMEOUT_MS.
  always_comb begin
    idle_d = idle_q;
    if (!in_edit || key_edge || step_up || step_dn || timeout) begin
      idle_d = '0;
    end else if (tick_1ms && (idle_q != TO_C)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Blink: solid on entry and after each step so the edited value is visible.
  assign entering = (state_d != NORMAL) && (state_d != state_q);

  always_comb begin
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (state_d == NORMAL) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (entering || step_up || step_dn) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (tick_1ms) begin
      if (bcnt_q + 1'b1 == BH_C) begin
        blink_d = ~blink_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // EOD gate: a pending tick and a fresh one on the first NORMAL cycle merge.
  always_comb begin
    if (in_edit) begin
      eod_d  = 1'b0;
      pend_d = pend_q | eod_in;
    end else begin
      eod_d  = eod_in | pend_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      idle_q  <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      pend_q  <= 1'b0;
      eod_q   <= 1'b0;
      pulse_q <= '0;
      field_q <= FLD_NONE;
      edit_q  <= 1'b0;
    end else begin
      mode_q  <= btn_mode;
      up_q    <= btn_up;
      down_q  <= btn_down;
      idle_q  <= idle_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      pend_q  <= pend_d;
      eod_q   <= eod_d;
      pulse_q <= pulse_d;
      field_q <= field_d;
      edit_q  <= edit_d;
    end
  end

  assign {inc_d, dec_d, inc_m, dec_m, inc_y, dec_y} = pulse_q;
  assign eod_out     = eod_q;
  assign edit_active = edit_q;
  assign field_sel   = field_q;
  assign blink       = blink_q;

endmodule
